uart_rx_fifo: RTL and testbench

//  Receive buffer placed directly downstream of uart_rx. Detects frame completion on uart_rx ready/data_out/error.

---
 rtl/uart_rx_fifo_if.sv | 32 +++
 rtl/uart_rx_fifo.sv | 97 +++++++++
 tb/tb_uart_rx_fifo.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Receive-buffer bus: uart_rx frame inputs on one side, show-ahead pop port
// and status flags on the other.
interface uart_rx_fifo_if #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                 rx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_error;
    logic [DATA_BITS-1:0] dout;
    logic                 dout_err;
    logic                 dout_valid;
    logic                 dout_ready;
    logic [CW-1:0]        count;
    logic                 full;
    logic                 empty;
    logic                 overflow;
    logic                 overflow_clr;

    // master: the uart_rx + consumer side; slave: the FIFO itself
    modport master (
        output rx_ready, rx_data, rx_error, dout_ready, overflow_clr,
        input  dout, dout_err, dout_valid, count, full, empty, overflow
    );

    modport slave (
        input  rx_ready, rx_data, rx_error, dout_ready, overflow_clr,
        output dout, dout_err, dout_valid, count, full, empty, overflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind uart_rx: pushes {error, data} on each rising edge of
// rx_ready and exposes the head entry on a show-ahead valid/ready port.
module uart_rx_fifo #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 8,
    parameter int DROP_ERR  = 0
) (
    input logic            clk,
    input logic            rst_n,
    uart_rx_fifo_if.slave  bus
);
    localparam int   AW          = $clog2(DEPTH);
    localparam int   CW          = AW + 1;
    localparam logic DROP_ERR_EN = (DROP_ERR != 0);

    typedef struct packed {
        logic                 err;
        logic [DATA_BITS-1:0] data;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            rx_ready_q, rx_ready_d;

    logic            frame_done, push_req, push, pop, drop;
    logic            full, empty;
    entry_t          head;

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        full       = (count_q == CW'(DEPTH));
        empty      = (count_q == '0);
        rx_ready_d = bus.rx_ready;
        frame_done = bus.rx_ready & ~rx_ready_q;
        push_req   = frame_done & ~(DROP_ERR_EN & bus.rx_error);
        pop        = ~empty & bus.dout_ready;
        // A pop in the same cycle frees the slot a full FIFO would otherwise lack
        push       = push_req & (~full | pop);
        drop       = push_req & full & ~pop;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A fresh drop outranks a clear arriving in the same cycle
        if (drop)                  overflow_d = 1'b1;
        else if (bus.overflow_clr) overflow_d = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rx_ready_q <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            rx_ready_q <= rx_ready_d;
        end
    end

    // NOTE: the storage array has no reset; stale contents are unreachable
    // because the pointers and count restart at zero.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{err: bus.rx_error, data: bus.rx_data};
    end

    assign head           = mem_q[rd_ptr_q];
    // Gated with empty so the port reads zero out of reset, not stale storage
    assign bus.dout       = empty ? '0 : head.data;
    assign bus.dout_err   = empty ? 1'b0 : head.err;
    assign bus.dout_valid = ~empty;
    assign bus.count      = count_q;
    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: two instances (DROP_ERR=0 and 1) share one stimulus
// stream; a queue per instance holds the expected pop order.
module tb_uart_rx_fifo;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DATA_BITS(DW), .DEPTH(DEPTH)) bus0 ();
    uart_rx_fifo_if #(.DATA_BITS(DW), .DEPTH(DEPTH)) bus1 ();

    assign bus1.rx_ready     = bus0.rx_ready;
    assign bus1.rx_data      = bus0.rx_data;
    assign bus1.rx_error     = bus0.rx_error;
    assign bus1.dout_ready   = bus0.dout_ready;
    assign bus1.overflow_clr = bus0.overflow_clr;

    uart_rx_fifo #(.DATA_BITS(DW), .DEPTH(DEPTH), .DROP_ERR(0)) u_keep (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    uart_rx_fifo #(.DATA_BITS(DW), .DEPTH(DEPTH), .DROP_ERR(1)) u_drop (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    int          total = 0;
    int          bad   = 0;
    logic [DW:0] exp_q [2][$];
    logic        exp_ovf [2];
    logic        prev_rdy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_state(input int k, input logic [CW-1:0] cnt, input logic f,
                               input logic em, input logic v, input logic o,
                               input logic [DW:0] head);
        int n;
        n = exp_q[k].size();
        check($sformatf("count%0d", k), 32'(cnt), 32'(n));
        check($sformatf("full%0d", k),  32'(f),   32'(n == DEPTH));
        check($sformatf("empty%0d", k), 32'(em),  32'(n == 0));
        check($sformatf("valid%0d", k), 32'(v),   32'(n != 0));
        check($sformatf("ovf%0d", k),   32'(o),   32'(exp_ovf[k]));
        if (n != 0) check($sformatf("head%0d", k), 32'(head), 32'(exp_q[k][0]));
    endtask

    // One clock: drive at a falling edge, predict, then check at the next falling edge.
    task automatic cycle(input logic rdy, input logic [DW-1:0] d, input logic e,
                         input logic take, input logic clr);
        logic frame;
        bus0.rx_ready     = rdy;
        bus0.rx_data      = d;
        bus0.rx_error     = e;
        bus0.dout_ready   = take;
        bus0.overflow_clr = clr;
        #1;
        frame    = rdy & ~prev_rdy;
        prev_rdy = rdy;
        for (int k = 0; k < 2; k++) begin
            logic        pop, full_m, req;
            logic [DW:0] obs;
            obs    = (k == 0) ? {bus0.dout_err, bus0.dout} : {bus1.dout_err, bus1.dout};
            full_m = (exp_q[k].size() == DEPTH);
            pop    = take && (exp_q[k].size() != 0);
            req    = frame && !(k == 1 && e);
            if (pop) begin
                check($sformatf("pop%0d", k), 32'(obs), 32'(exp_q[k][0]));
                void'(exp_q[k].pop_front());
            end
            if (req && (!full_m || pop)) exp_q[k].push_back({e, d});
            if (req && full_m && !pop) exp_ovf[k] = 1'b1;
            else if (clr)              exp_ovf[k] = 1'b0;
        end
        @(negedge clk);
        check_state(0, bus0.count, bus0.full, bus0.empty, bus0.dout_valid, bus0.overflow,
                    {bus0.dout_err, bus0.dout});
        check_state(1, bus1.count, bus1.full, bus1.empty, bus1.dout_valid, bus1.overflow,
                    {bus1.dout_err, bus1.dout});
    endtask

    // uart_rx style frame: ready drops while receiving, then rises with the byte.
    task automatic frame(input logic [DW-1:0] d, input logic e, input logic take);
        cycle(1'b0, 8'h00, 1'b0, take, 1'b0);
        cycle(1'b1, d, e, take, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_count",  32'(bus0.count),      32'd0);
        check("rst_valid",  32'(bus0.dout_valid), 32'd0);
        check("rst_empty",  32'(bus0.empty),      32'd1);
        check("rst_full",   32'(bus0.full),       32'd0);
        check("rst_ovf",    32'(bus0.overflow),   32'd0);
        check("rst_dout",   32'(bus0.dout),       32'd0);
        check("rst_err",    32'(bus0.dout_err),   32'd0);
        check("rst_count1", 32'(bus1.count),      32'd0);
        check("rst_ovf1",   32'(bus1.overflow),   32'd0);
        for (int k = 0; k < 2; k++) begin
            exp_q[k].delete();
            exp_ovf[k] = 1'b0;
        end
        prev_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus0.rx_ready     = 1'b1;
        bus0.rx_data      = '0;
        bus0.rx_error     = 1'b0;
        bus0.dout_ready   = 1'b0;
        bus0.overflow_clr = 1'b0;
        @(negedge clk);
        do_reset();

        // single byte, one-cycle show-ahead latency
        frame(8'h41, 1'b0, 1'b0);
        check("t1_dout",  32'(bus0.dout),       32'h41);
        check("t1_valid", 32'(bus0.dout_valid), 32'd1);

        // second byte, then pop both down to empty
        frame(8'hA5, 1'b0, 1'b0);
        cycle(1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        check("t2_empty", 32'(bus0.empty), 32'd1);

        // fill, overflow on the ninth frame, drain, then clear the flag
        for (int i = 0; i < DEPTH; i++) frame(DW'(i), 1'b0, 1'b0);
        check("t3_full", 32'(bus0.full), 32'd1);
        frame(8'h08, 1'b0, 1'b0);
        check("t3_ovf",   32'(bus0.overflow), 32'd1);
        check("t3_count", 32'(bus0.count),    32'd8);
        drain();
        cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        check("t3_clr", 32'(bus0.overflow), 32'd0);

        // full FIFO: frame and pop together, then drop racing a clear
        for (int i = 0; i < DEPTH; i++) frame(8'h10 + DW'(i), 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
        check("t4_count", 32'(bus0.count),    32'd8);
        check("t4_ovf",   32'(bus0.overflow), 32'd0);
        frame(8'h55, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h66, 1'b0, 1'b0, 1'b1);
        check("t4_drop_wins", 32'(bus0.overflow), 32'd1);
        drain();
        cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);

        // errored frame: stored with flag on one instance, discarded on the other
        frame(8'h3C, 1'b1, 1'b0);
        check("t5_err_keep",  32'(bus0.dout_err), 32'd1);
        check("t5_cnt_drop",  32'(bus1.count),    32'd0);
        check("t5_ovf_drop",  32'(bus1.overflow), 32'd0);
        frame(8'h3D, 1'b0, 1'b0);
        drain();

        // reset with data held and uart_rx mid-frame
        for (int i = 0; i < 3; i++) frame(8'hC0 + DW'(i), 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        do_reset();
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'h7E, 1'b0, 1'b0, 1'b0);
        check("t6_once", 32'(bus0.count), 32'd1);
        drain();

        // sustained traffic: a frame every other cycle with the consumer always ready
        for (int i = 0; i < 20; i++) frame(DW'($urandom), 1'b0, 1'b1);

        // random mix of frames, errors, pops and clears
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), DW'($urandom), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
